multi_lane_fifo: RTL and testbench

- Next-generation multi-push/multi-pop FIFO for the UART/FFT datapath. Up to N_PUSH words written and up to N_POP words read per cycle, with push and pop widths set independently.
- Any depth D is supported, including non-powers of two.
- Adds over the previous block:
  - request clamping with sticky overflow/underflow flags;
  - an occupancy count output;
  - programmable almost-full/almost-empty outputs;
  - a synchronous flush.
- Sits between bursty producers (e.g. UART byte assembly) and wide consumers (FFT sample loader).

---
 rtl/multi_lane_fifo_if.sv | 36 +++
 rtl/multi_lane_fifo.sv | 97 +++++++++
 tb/tb_multi_lane_fifo.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/multi_lane_fifo_if.sv
// Push/pop bus of the multi-lane FIFO: producer and consumer drive the master side, the FIFO is the slave.
// Lane 0 of push_data/pop_data is always the oldest word.
interface multi_lane_fifo_if #(
  parameter int W      = 16,
  parameter int D      = 16,
  parameter int N_PUSH = 2,
  parameter int N_POP  = 2
);
  localparam int WP = $clog2(N_PUSH + 1);
  localparam int WQ = $clog2(N_POP + 1);
  localparam int CW = $clog2(D + 1);

  logic                       flush;
  logic                       err_clr;
  logic [WP-1:0]              push;
  logic [N_PUSH-1:0][W-1:0]   push_data;
  logic [WQ-1:0]              pop;
  logic [N_POP-1:0][W-1:0]    pop_data;
  logic [WP-1:0]              can_push;
  logic [WQ-1:0]              can_pop;
  logic [CW-1:0]              count;
  logic                       almost_full;
  logic                       almost_empty;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output flush, err_clr, push, push_data, pop,
    input  pop_data, can_push, can_pop, count, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  flush, err_clr, push, push_data, pop,
    output pop_data, can_push, can_pop, count, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/multi_lane_fifo.sv
// Multi-push/multi-pop FIFO; pushed words are poppable one cycle later, pop_data is show-ahead.
// Over-size requests are clamped to can_push/can_pop (functions of count only) and flagged sticky.
module multi_lane_fifo #(
  parameter int W        = 16,
  parameter int D        = 16,
  parameter int N_PUSH   = 2,
  parameter int N_POP    = 2,
  parameter int AF_LEVEL = D - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rst,
  multi_lane_fifo_if.slave  bus
);
  localparam int WP = $clog2(N_PUSH + 1);
  localparam int WQ = $clog2(N_POP + 1);
  localparam int CW = $clog2(D + 1);
  localparam int AW = (D > 1) ? $clog2(D) : 1;

  localparam logic [CW:0] D_X  = (CW+1)'(D);
  localparam logic [CW:0] NP_X = (CW+1)'(N_PUSH);
  localparam logic [CW:0] NQ_X = (CW+1)'(N_POP);

  logic [W-1:0]  mem [D];
  logic [CW-1:0] wr_ptr, rd_ptr, count_q;
  logic          overflow_q, underflow_q;

  logic [CW:0]   space;
  logic [WP-1:0] can_push_c, acc_push;
  logic [WQ-1:0] can_pop_c, acc_pop;
  logic          ovf_evt, unf_evt;

  // The sum is formed one bit wider than the pointer so a non-power-of-two D wraps correctly.
  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] p, input logic [CW:0] k);
    logic [CW:0] s;
    s = {1'b0, p} + k;
    if (s >= D_X) s = s - D_X;
    return CW'(s);
  endfunction

  always_comb begin
    space      = D_X - {1'b0, count_q};
    can_push_c = (space >= NP_X) ? WP'(N_PUSH) : WP'(space);
    can_pop_c  = ({1'b0, count_q} >= NQ_X) ? WQ'(N_POP) : WQ'(count_q);
    ovf_evt    = bus.push > can_push_c;
    unf_evt    = bus.pop > can_pop_c;
    acc_push   = ovf_evt ? can_push_c : bus.push;
    acc_pop    = unf_evt ? can_pop_c : bus.pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        wr_ptr  <= wrap_add(wr_ptr, (CW+1)'(acc_push));
        rd_ptr  <= wrap_add(rd_ptr, (CW+1)'(acc_pop));
        count_q <= CW'({1'b0, count_q} + (CW+1)'(acc_push) - (CW+1)'(acc_pop));
      end
      // A new violation outranks err_clr; requests discarded by flush never raise a flag.
      if (ovf_evt && !bus.flush)      overflow_q <= 1'b1;
      else if (bus.err_clr)           overflow_q <= 1'b0;
      if (unf_evt && !bus.flush)      underflow_q <= 1'b1;
      else if (bus.err_clr)           underflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.flush) begin
      for (int i = 0; i < N_PUSH; i++) begin
        if (i < int'(acc_push))
          mem[AW'(wrap_add(wr_ptr, (CW+1)'(i)))] <= bus.push_data[i];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N_POP; j++)
      bus.pop_data[j] = mem[AW'(wrap_add(rd_ptr, (CW+1)'(j)))];
  end

  assign bus.can_push     = can_push_c;
  assign bus.can_pop      = can_pop_c;
  assign bus.count        = count_q;
  assign bus.almost_full  = int'(count_q) >= AF_LEVEL;
  assign bus.almost_empty = int'(count_q) <= AE_LEVEL;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_multi_lane_fifo.sv
// Directed bench for multi_lane_fifo at W=8, D=5, N_PUSH=3, N_POP=2, AF_LEVEL=4, AE_LEVEL=1.
module tb_multi_lane_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  multi_lane_fifo_if #(.W(8), .D(5), .N_PUSH(3), .N_POP(2)) bus ();

  multi_lane_fifo #(
    .W(8), .D(5), .N_PUSH(3), .N_POP(2), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.push = 2'd0; bus.pop = 2'd0; bus.flush = 1'b0; bus.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.push_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    bus.push = 2'd3; bus.push_data = {8'h12, 8'h11, 8'h10};
    step();
    bus.push = 2'd3; bus.push_data = {8'h15, 8'h14, 8'h13};
    step();
    idle();
    vectors++; if (bus.count !== 3'd5) begin miscompares++; $display("FAIL pre_reset_count got %0d want 5", bus.count); end
    vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL pre_reset_ovf got %0b want 1", bus.overflow); end
    @(negedge clk); rst = 1'b1; #1;
    vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", bus.count); end
    vectors++; if (bus.can_push !== 2'd3) begin miscompares++; $display("FAIL rst_can_push got %0d want 3", bus.can_push); end
    vectors++; if (bus.can_pop !== 2'd0) begin miscompares++; $display("FAIL rst_can_pop got %0d want 0", bus.can_pop); end
    vectors++; if (bus.almost_empty !== 1'b1) begin miscompares++; $display("FAIL rst_ae got %0b want 1", bus.almost_empty); end
    vectors++; if (bus.almost_full !== 1'b0) begin miscompares++; $display("FAIL rst_af got %0b want 0", bus.almost_full); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got %0b want 0", bus.overflow); end
    vectors++; if (bus.underflow !== 1'b0) begin miscompares++; $display("FAIL rst_unf got %0b want 0", bus.underflow); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    bus.push = 2'd3; bus.push_data = {8'hA2, 8'hA1, 8'hA0};
    step();
    vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL fill1_count got %0d want 3", bus.count); end
    vectors++; if (bus.can_push !== 2'd2) begin miscompares++; $display("FAIL fill1_can_push got %0d want 2", bus.can_push); end
    bus.push = 2'd2; bus.push_data = {8'hFF, 8'hB1, 8'hB0};
    step();
    idle();
    vectors++; if (bus.count !== 3'd5) begin miscompares++; $display("FAIL full_count got %0d want 5", bus.count); end
    vectors++; if (bus.can_push !== 2'd0) begin miscompares++; $display("FAIL full_can_push got %0d want 0", bus.can_push); end
    vectors++; if (bus.can_pop !== 2'd2) begin miscompares++; $display("FAIL full_can_pop got %0d want 2", bus.can_pop); end
    vectors++; if (bus.almost_full !== 1'b1) begin miscompares++; $display("FAIL full_af got %0b want 1", bus.almost_full); end
    vectors++; if (bus.almost_empty !== 1'b0) begin miscompares++; $display("FAIL full_ae got %0b want 0", bus.almost_empty); end
    vectors++; if (bus.pop_data[0] !== 8'hA0) begin miscompares++; $display("FAIL full_lane0 got %h want a0", bus.pop_data[0]); end
    vectors++; if (bus.pop_data[1] !== 8'hA1) begin miscompares++; $display("FAIL full_lane1 got %h want a1", bus.pop_data[1]); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL full_ovf got %0b want 0", bus.overflow); end
  endtask

  task automatic test_wrap();
    bus.pop = 2'd2;
    step();
    vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL wrap1_count got %0d want 3", bus.count); end
    vectors++; if (bus.pop_data[0] !== 8'hA2) begin miscompares++; $display("FAIL wrap1_lane0 got %h want a2", bus.pop_data[0]); end
    vectors++; if (bus.pop_data[1] !== 8'hB0) begin miscompares++; $display("FAIL wrap1_lane1 got %h want b0", bus.pop_data[1]); end
    bus.pop = 2'd2; bus.push = 2'd2; bus.push_data = {8'hEE, 8'hC1, 8'hC0};
    step();
    idle();
    vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL wrap2_count got %0d want 3", bus.count); end
    vectors++; if (bus.pop_data[0] !== 8'hB1) begin miscompares++; $display("FAIL wrap2_lane0 got %h want b1", bus.pop_data[0]); end
    vectors++; if (bus.pop_data[1] !== 8'hC0) begin miscompares++; $display("FAIL wrap2_lane1 got %h want c0", bus.pop_data[1]); end
    bus.pop = 2'd2;
    step();
    idle();
    vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL wrap3_count got %0d want 1", bus.count); end
    vectors++; if (bus.pop_data[0] !== 8'hC1) begin miscompares++; $display("FAIL wrap3_lane0 got %h want c1", bus.pop_data[0]); end
    vectors++; if (bus.can_pop !== 2'd1) begin miscompares++; $display("FAIL wrap3_can_pop got %0d want 1", bus.can_pop); end
    vectors++; if (bus.almost_empty !== 1'b1) begin miscompares++; $display("FAIL wrap3_ae got %0b want 1", bus.almost_empty); end
    vectors++; if ({bus.overflow, bus.underflow} !== 2'b00) begin miscompares++; $display("FAIL wrap_flags got %b want 00", {bus.overflow, bus.underflow}); end
  endtask

  task automatic test_overflow();
    bus.push = 2'd3; bus.push_data = {8'hE2, 8'hE1, 8'hE0};
    step();
    vectors++; if (bus.count !== 3'd4) begin miscompares++; $display("FAIL ovf_pre_count got %0d want 4", bus.count); end
    vectors++; if (bus.can_push !== 2'd1) begin miscompares++; $display("FAIL ovf_pre_can_push got %0d want 1", bus.can_push); end
    vectors++; if (bus.almost_full !== 1'b1) begin miscompares++; $display("FAIL ovf_pre_af got %0b want 1", bus.almost_full); end
    bus.push = 2'd3; bus.push_data = {8'h5A, 8'h59, 8'h58};
    step();
    idle();
    vectors++; if (bus.count !== 3'd5) begin miscompares++; $display("FAIL ovf_count got %0d want 5", bus.count); end
    vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %0b want 1", bus.overflow); end
    step();
    vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_hold got %0b want 1", bus.overflow); end
    bus.err_clr = 1'b1;
    step();
    idle();
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr got %0b want 0", bus.overflow); end
    bus.pop = 2'd2;
    step();
    vectors++; if (bus.pop_data[0] !== 8'hE1) begin miscompares++; $display("FAIL ovf_drain1 got %h want e1", bus.pop_data[0]); end
    step();
    idle();
    vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL ovf_drain_count got %0d want 1", bus.count); end
    vectors++; if (bus.pop_data[0] !== 8'h58) begin miscompares++; $display("FAIL ovf_only_x got %h want 58", bus.pop_data[0]); end
  endtask

  task automatic test_underflow();
    bus.pop = 2'd2;
    step();
    idle();
    vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL unf_count got %0d want 0", bus.count); end
    vectors++; if (bus.underflow !== 1'b1) begin miscompares++; $display("FAIL unf_set got %0b want 1", bus.underflow); end
    vectors++; if (bus.almost_empty !== 1'b1) begin miscompares++; $display("FAIL unf_ae got %0b want 1", bus.almost_empty); end
    vectors++; if (bus.can_pop !== 2'd0) begin miscompares++; $display("FAIL unf_can_pop got %0d want 0", bus.can_pop); end
    bus.push = 2'd1; bus.push_data = {8'h00, 8'h00, 8'hF0};
    step();
    idle();
    vectors++; if (bus.pop_data[0] !== 8'hF0) begin miscompares++; $display("FAIL unf_rdptr got %h want f0", bus.pop_data[0]); end
    bus.pop = 2'd2; bus.err_clr = 1'b1;
    step();
    idle();
    vectors++; if (bus.underflow !== 1'b1) begin miscompares++; $display("FAIL unf_set_wins got %0b want 1", bus.underflow); end
    bus.err_clr = 1'b1;
    step();
    idle();
    vectors++; if (bus.underflow !== 1'b0) begin miscompares++; $display("FAIL unf_clr got %0b want 0", bus.underflow); end
  endtask

  task automatic test_flush();
    bus.push = 2'd3; bus.push_data = {8'h72, 8'h71, 8'h70};
    step();
    vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL fl_pre_count got %0d want 3", bus.count); end
    bus.push = 2'd2; bus.flush = 1'b1; bus.push_data = {8'h00, 8'h81, 8'h80};
    step();
    idle();
    vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL fl_count got %0d want 0", bus.count); end
    vectors++; if (bus.can_pop !== 2'd0) begin miscompares++; $display("FAIL fl_can_pop got %0d want 0", bus.can_pop); end
    vectors++; if ({bus.overflow, bus.underflow} !== 2'b00) begin miscompares++; $display("FAIL fl_flags got %b want 00", {bus.overflow, bus.underflow}); end
    bus.push = 2'd1; bus.push_data = {8'h00, 8'h00, 8'hD0};
    step();
    idle();
    vectors++; if (bus.pop_data[0] !== 8'hD0) begin miscompares++; $display("FAIL fl_d0 got %h want d0", bus.pop_data[0]); end
    vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL fl_d0_count got %0d want 1", bus.count); end
    bus.pop = 2'd2; bus.flush = 1'b1;
    step();
    idle();
    vectors++; if (bus.underflow !== 1'b0) begin miscompares++; $display("FAIL fl_no_unf got %0b want 0", bus.underflow); end
    bus.push = 2'd3; bus.push_data = {8'h93, 8'h92, 8'h91};
    step();
    step();
    idle();
    vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL fl_ovf_setup got %0b want 1", bus.overflow); end
    bus.flush = 1'b1;
    step();
    idle();
    vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL fl_keeps_ovf got %0b want 1", bus.overflow); end
    vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL fl2_count got %0d want 0", bus.count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_overflow();
    test_underflow();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
